wb_trace_checker: RTL and testbench
===================================

# wb_trace_checker

Synthesizable retirement checker that sits downstream of the single-cycle `core` and consumes its fetch address, instruction, write-back debug port and data-SRAM store bus. It walks a loadable table of expected retirement records, tracks which record is due next, tolerates skipped PCs from taken branches and jumps, and reports pass count, done and a sticky failure with cause and index. It replaces hand-written per-address waits in benches and can also run on FPGA as a self-test monitor.

## Interface
Parameters:
- `DEPTH`, 16, number of expected-record slots (power of two, ≥2)
- `TIMEOUT`, 64, cycles allowed without a matching PC before failure

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `load_en`  in  1  write one record into the table (accepted only in IDLE/DONE/FAIL)
- `load_idx`  in  $clog2(DEPTH)  table slot to write
- `load_rec`  in  103  record {kind[102:101], pc[100:69], dst[68:64], val[63:32], addr[31:0]}
- `start`  in  1  one-cycle pulse that begins a check run
- `num_rec`  in  $clog2(DEPTH)+1  records in this run, sampled on `start`
- `inst_addr`  in  32  core fetch address
- `inst_data`  in  32  core instruction word (unused by checks; kept for debug waveform)
- `wb_dat`  in  32  core write-back data
- `wb_dst`  in  5  core write-back register
- `st_addr`  in  32  data-SRAM address
- `st_wdata`  in  32  data-SRAM write data
- `busy`  out  1  high in RUN
- `done`  out  1  high in DONE
- `fail`  out  1  high in FAIL
- `fail_code`  out  2  0 none, 1 write-back mismatch, 2 store mismatch, 3 timeout
- `fail_idx`  out  $clog2(DEPTH)  record index at failure
- `pass_cnt`  out  $clog2(DEPTH)+1  records matched this run

## Operation
- Record kinds: 0 = PC-only (branch/jump), 1 = write-back check (`wb_dst==dst && wb_dat==val`), 2 = store check (`st_addr==addr && st_wdata==val`), 3 = reserved, treated as PC-only.
- FSM states: IDLE, RUN, DONE, FAIL.
- IDLE/DONE/FAIL --`start`--> RUN: `ptr`←0, `pass_cnt`←0, timeout counter←0, `fail_code`←0, `fail_idx`←0. If `num_rec`==0, go directly to DONE.
- RUN, each cycle, against record `ptr`:
  - `inst_addr`≠pc: timeout counter +1; non-matching PCs are skipped silently.
  - `inst_addr`==pc and kind check passes: `ptr`+1, `pass_cnt`+1, timeout counter←0; if `ptr`+1==`num_rec`, go to DONE.
  - `inst_addr`==pc and check fails: go to FAIL with `fail_code` 1 or 2 and `fail_idx`←`ptr`.
- FAIL is sticky until `start` or `rst`; `pass_cnt` and `fail_idx` hold.
- `start` in RUN is ignored. `load_en` in RUN is ignored; the table is never modified mid-run.
- `num_rec` > DEPTH is clamped to DEPTH.
- Table contents are not cleared by `rst`; all other state is.

## Timing
- Reset values: `busy`=0, `done`=0, `fail`=0, `fail_code`=0, `fail_idx`=0, `pass_cnt`=0, state IDLE.
- Inputs are compared combinationally and results are registered. A match at edge N shows in `pass_cnt`, `done` or `fail` after edge N, with one cycle of latency.
- `start` at edge N: `busy`=1 after N. The first comparison happens at edge N+1.
- A load at edge N is readable by a run started at edge N+1 or later.
- `rst` mid-run returns to IDLE immediately, asynchronously.

## Configuration
- `WB_TRACE_TIMEOUT_EN` defined: in RUN, when the timeout counter reaches `TIMEOUT` (TIMEOUT consecutive non-matching cycles), go to FAIL with `fail_code`=3 and `fail_idx`=`ptr`.
- `WB_TRACE_TIMEOUT_EN` undefined: no counter is built, `fail_code` never equals 3, and a missing PC leaves the checker in RUN indefinitely.

## Test plan
- Load 3 records {1, 0x0, r2, 5}, {1, 0x4, r3, 12}, {0, 0x18}, then drive a retirement stream matching them with `num_rec`=3 -> `pass_cnt` steps 1,2,3, `done`=1 one cycle after the 0x18 cycle, `fail`=0.
- Record {1, 0x8, r7, 3}, core presents `wb_dat`=4 at PC 0x8 -> `fail`=1, `fail_code`=1, `fail_idx`=0; stays sticky through 10 more cycles.
- Store record {2, 0x34, -, 7, 80}, stream presents `st_addr`=84 at 0x34 -> `fail_code`=2. The same stream with `st_addr`=80 -> pass.
- Records at 0x20 and 0x28, with PC 0x24 skipped in the stream -> `done`=1 and `pass_cnt`=2. Separately, a stream that never reaches PC 0x28 with the macro defined -> `fail_code`=3 exactly `TIMEOUT` cycles after the last match.
- Assert `rst` mid-run at `pass_cnt`=2 -> all outputs 0 immediately. A fresh `start` with the table untouched then runs to `done`. Also cover `start` with `num_rec`=0 -> `done` the next cycle.

Source files
------------

// File: rtl/wb_trace_checker.sv
// Retirement trace checker: walks a table of expected PC/write-back/store records.
// Optional WB_TRACE_TIMEOUT_EN builds a no-progress timeout that fails the run.
module wb_trace_checker #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_en,
    input  logic [$clog2(DEPTH)-1:0]   load_idx,
    input  logic [102:0]               load_rec,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     num_rec,
    input  logic [31:0]                inst_addr,
    input  logic [31:0]                inst_data,
    input  logic [31:0]                wb_dat,
    input  logic [4:0]                 wb_dst,
    input  logic [31:0]                st_addr,
    input  logic [31:0]                st_wdata,
    output logic                       busy,
    output logic                       done,
    output logic                       fail,
    output logic [1:0]                 fail_code,
    output logic [$clog2(DEPTH)-1:0]   fail_idx,
    output logic [$clog2(DEPTH):0]     pass_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;

    state_t        state;
    logic [102:0]  table_mem [DEPTH];
    logic [AW-1:0] ptr;
    logic [AW:0]   n_rec;
    logic [AW:0]   ptr_inc;

    logic [102:0]  rec;
    logic [1:0]    rec_kind;
    logic [31:0]   rec_pc;
    logic [4:0]    rec_dst;
    logic [31:0]   rec_val;
    logic [31:0]   rec_addr;
    logic          pc_hit;
    logic          chk_ok;
    logic [AW:0]   n_clamp;

    // inst_data is carried only so it shows up next to the PC in waveforms
    logic          unused_inst;
    logic [TW-1:0] unused_tw;
    assign unused_inst = ^inst_data;
    assign unused_tw   = TW'(TIMEOUT);

    assign rec      = table_mem[ptr];
    assign rec_kind = rec[102:101];
    assign rec_pc   = rec[100:69];
    assign rec_dst  = rec[68:64];
    assign rec_val  = rec[63:32];
    assign rec_addr = rec[31:0];
    assign pc_hit   = (inst_addr == rec_pc);
    assign ptr_inc  = {1'b0, ptr} + (AW+1)'(1);
    assign n_clamp  = (num_rec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_rec;

    always_comb begin
        chk_ok = 1'b1;
        case (rec_kind)
            2'd1:    chk_ok = (wb_dst == rec_dst) && (wb_dat == rec_val);
            2'd2:    chk_ok = (st_addr == rec_addr) && (st_wdata == rec_val);
            default: chk_ok = 1'b1;
        endcase
    end

    // Table is intentionally outside reset so a run can be repeated after rst
    always_ff @(posedge clk) begin
        if (load_en && state != RUN)
            table_mem[load_idx] <= load_rec;
    end

`ifdef WB_TRACE_TIMEOUT_EN
    logic [TW-1:0] tmo_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= 2'd0;
            fail_idx  <= '0;
            pass_cnt  <= '0;
            ptr       <= '0;
            n_rec     <= '0;
`ifdef WB_TRACE_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            unique case (state)
                RUN: begin
                    if (pc_hit) begin
                        if (chk_ok) begin
                            ptr      <= ptr_inc[AW-1:0];
                            pass_cnt <= pass_cnt + (AW+1)'(1);
`ifdef WB_TRACE_TIMEOUT_EN
                            tmo_cnt  <= '0;
`endif
                            if (ptr_inc == n_rec) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            state     <= FAIL;
                            busy      <= 1'b0;
                            fail      <= 1'b1;
                            fail_code <= (rec_kind == 2'd2) ? 2'd2 : 2'd1;
                            fail_idx  <= ptr;
                        end
                    end else begin
`ifdef WB_TRACE_TIMEOUT_EN
                        if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                            state     <= FAIL;
                            busy      <= 1'b0;
                            fail      <= 1'b1;
                            fail_code <= 2'd3;
                            fail_idx  <= ptr;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
`endif
                    end
                end
                default: begin
                    if (start) begin
                        ptr       <= '0;
                        pass_cnt  <= '0;
                        fail_code <= 2'd0;
                        fail_idx  <= '0;
                        n_rec     <= n_clamp;
                        fail      <= 1'b0;
`ifdef WB_TRACE_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                        if (n_clamp == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker with hand-computed expectations.
// Timeout scenario is exact when built with WB_TRACE_TIMEOUT_EN.
module tb_wb_trace_checker;
    localparam int DEPTH = 16;
    localparam int TMO   = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_en;
    logic [3:0]   load_idx;
    logic [102:0] load_rec;
    logic         start;
    logic [4:0]   num_rec;
    logic [31:0]  inst_addr, inst_data, wb_dat, st_addr, st_wdata;
    logic [4:0]   wb_dst;
    logic         busy, done, fail;
    logic [1:0]   fail_code;
    logic [3:0]   fail_idx;
    logic [4:0]   pass_cnt;

    int errors = 0;
    int checks = 0;

    wb_trace_checker #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_idx(load_idx),
        .load_rec(load_rec), .start(start), .num_rec(num_rec),
        .inst_addr(inst_addr), .inst_data(inst_data), .wb_dat(wb_dat),
        .wb_dst(wb_dst), .st_addr(st_addr), .st_wdata(st_wdata),
        .busy(busy), .done(done), .fail(fail), .fail_code(fail_code),
        .fail_idx(fail_idx), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ld(input int idx, input logic [1:0] k, input logic [31:0] pc,
                      input logic [4:0] dst, input logic [31:0] val,
                      input logic [31:0] addr);
        load_en  = 1'b1;
        load_idx = idx[3:0];
        load_rec = {k, pc, dst, val, addr};
        tick();
        load_en  = 1'b0;
    endtask

    task automatic go(input int n);
        start   = 1'b1;
        num_rec = n[4:0];
        tick();
        start   = 1'b0;
    endtask

    task automatic ret(input logic [31:0] pc, input logic [4:0] dst,
                       input logic [31:0] dat, input logic [31:0] sa,
                       input logic [31:0] sd);
        inst_addr = pc;
        inst_data = 32'h0000_0013;
        wb_dst    = dst;
        wb_dat    = dat;
        st_addr   = sa;
        st_wdata  = sd;
        tick();
    endtask

    task automatic chk_status(input string tag, input logic b, input logic d,
                              input logic f, input logic [1:0] c,
                              input logic [3:0] i, input logic [4:0] p);
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
        chk({tag, ".fail"}, 32'(fail), 32'(f));
        chk({tag, ".code"}, 32'(fail_code), 32'(c));
        chk({tag, ".idx"}, 32'(fail_idx), 32'(i));
        chk({tag, ".pass"}, 32'(pass_cnt), 32'(p));
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; load_idx = '0; load_rec = '0;
        start = 1'b0; num_rec = '0;
        inst_addr = 32'hFFFF_FFF0; inst_data = '0; wb_dat = '0;
        wb_dst = '0; st_addr = '0; st_wdata = '0;
        #12;
        chk_status("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_status("idle", 0, 0, 0, 0, 0, 0);

        // basic three-record stream with a skipped PC
        ld(0, 2'd1, 32'h0, 5'd2, 32'd5, 32'h0);
        ld(1, 2'd1, 32'h4, 5'd3, 32'd12, 32'h0);
        ld(2, 2'd0, 32'h18, 5'd0, 32'h0, 32'h0);
        go(3);
        chk("t1.busy", 32'(busy), 1);
        ret(32'h0, 5'd2, 32'd5, 0, 0);
        chk("t1.p1", 32'(pass_cnt), 1);
        ret(32'h4, 5'd3, 32'd12, 0, 0);
        chk("t1.p2", 32'(pass_cnt), 2);
        // start and load while running must both be ignored
        start = 1'b1; num_rec = 5'd0;
        load_en = 1'b1; load_idx = 4'd2; load_rec = {2'd0, 32'h99, 69'h0};
        ret(32'h8, 5'd9, 32'd1, 0, 0);
        start = 1'b0; load_en = 1'b0;
        chk_status("t1.skip", 1, 0, 0, 0, 0, 2);
        ret(32'h18, 5'd0, 32'd0, 0, 0);
        chk_status("t1.done", 0, 1, 0, 0, 0, 3);

        // write-back mismatch, sticky
        ld(0, 2'd1, 32'h8, 5'd7, 32'd3, 32'h0);
        go(1);
        ret(32'h8, 5'd7, 32'd4, 0, 0);
        chk_status("t2.fail", 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) ret(32'h8, 5'd7, 32'd3, 0, 0);
        chk_status("t2.sticky", 0, 0, 1, 1, 0, 0);

        // store mismatch then match
        ld(0, 2'd2, 32'h34, 5'd0, 32'd7, 32'd80);
        go(1);
        ret(32'h34, 5'd0, 32'd0, 32'd84, 32'd7);
        chk_status("t3.bad", 0, 0, 1, 2, 0, 0);
        go(1);
        chk_status("t3.rerun", 1, 0, 0, 0, 0, 0);
        ret(32'h34, 5'd0, 32'd0, 32'd80, 32'd7);
        chk_status("t3.good", 0, 1, 0, 0, 0, 1);

        // skipped PC between two branch records
        ld(0, 2'd0, 32'h20, 5'd0, 32'h0, 32'h0);
        ld(1, 2'd0, 32'h28, 5'd0, 32'h0, 32'h0);
        go(2);
        ret(32'h20, 0, 0, 0, 0);
        ret(32'h24, 0, 0, 0, 0);
        ret(32'h28, 0, 0, 0, 0);
        chk_status("t4.skip", 0, 1, 0, 0, 0, 2);

        // missing PC 0x28
        go(2);
        ret(32'h20, 0, 0, 0, 0);
`ifdef WB_TRACE_TIMEOUT_EN
        for (int i = 0; i < TMO - 1; i++) ret(32'h2C, 0, 0, 0, 0);
        chk_status("t5.pre", 1, 0, 0, 0, 0, 1);
        ret(32'h2C, 0, 0, 0, 0);
        chk_status("t5.tmo", 0, 0, 1, 3, 1, 1);
`else
        for (int i = 0; i < TMO + 16; i++) ret(32'h2C, 0, 0, 0, 0);
        chk_status("t5.hang", 1, 0, 0, 0, 0, 1);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        @(negedge clk);
`endif

        // asynchronous reset mid-run, then rerun on the untouched table
        ld(2, 2'd1, 32'h30, 5'd5, 32'h55, 32'h0);
        go(3);
        ret(32'h20, 0, 0, 0, 0);
        ret(32'h28, 0, 0, 0, 0);
        chk("t6.p2", 32'(pass_cnt), 2);
        #2;
        rst = 1'b1;
        #1;
        chk_status("t6.rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        go(3);
        ret(32'h20, 0, 0, 0, 0);
        ret(32'h28, 0, 0, 0, 0);
        ret(32'h30, 5'd5, 32'h55, 0, 0);
        chk_status("t6.rerun", 0, 1, 0, 0, 0, 3);

        // zero-length run
        go(0);
        chk_status("t7.zero", 0, 1, 0, 0, 0, 0);

        // num_rec above DEPTH clamps; kind 3 behaves as PC-only
        for (int i = 0; i < DEPTH; i++)
            ld(i, (i % 4 == 3) ? 2'd3 : 2'd0, 32'(i * 4), 5'd0, 32'h0, 32'h0);
        go(20);
        for (int i = 0; i < DEPTH; i++) ret(32'(i * 4), 5'd1, 32'h1, 0, 0);
        chk_status("t8.clamp", 0, 1, 0, 0, 0, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
